// File: rtl/pipe_shifter.sv
// Elastic barrel shifter: stage 0 registers the operand (and its leading-zero count
// for NORM), then SHW stages each apply one shift-amount bit, MSB first.
module pipe_shifter #(
    parameter int   WIDTH = 24,
    localparam int  SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_amt,
    output logic             out_sticky,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_LSL  = 2'b00,
        MODE_LSR  = 2'b01,
        MODE_ASR  = 2'b10,
        MODE_NORM = 2'b11
    } mode_e;

    logic [SHW:0]     valid_q;
    logic [SHW:0]     feed_valid;
    logic [SHW:0]     load;

    logic [WIDTH-1:0] data_q   [0:SHW];
    logic [WIDTH-1:0] data_d   [0:SHW];
    logic [SHW-1:0]   amt_q    [0:SHW];
    logic [SHW-1:0]   amt_d    [0:SHW];
    logic             sticky_q [0:SHW];
    logic             sticky_d [0:SHW];
    mode_e            mode_q   [0:SHW-1];
    mode_e            mode_d   [0:SHW-1];

    function automatic logic [SHW-1:0] lzc(input logic [WIDTH-1:0] x);
        logic [SHW-1:0] n;
        logic           found;
        n     = SHW'(WIDTH);
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && x[WIDTH-1-i]) begin
                n     = SHW'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin : ready_chain
        logic nxt;
        load      = '0;
        nxt       = ~valid_q[SHW] | out_ready;
        load[SHW] = nxt;
        for (int unsigned i = 1; i <= SHW; i++) begin
            nxt             = ~valid_q[SHW-i] | nxt;
            load[SHW-i]     = nxt;
        end
    end

    assign feed_valid = {valid_q[SHW-1:0], in_valid};
    assign in_ready   = load[0] & ~rst;

    always_comb begin : datapath
        int unsigned      sh;
        logic [WIDTH-1:0] src;
        data_d[0]   = in_data;
        amt_d[0]    = (mode_e'(in_mode) == MODE_NORM) ? lzc(in_data) : in_amt;
        sticky_d[0] = 1'b0;
        mode_d[0]   = mode_e'(in_mode);
        for (int unsigned k = 1; k < SHW; k++) begin
            mode_d[k] = mode_q[k-1];
        end
        for (int unsigned k = 1; k <= SHW; k++) begin
            sh          = 32'd1 << (SHW - k);
            src         = data_q[k-1];
            data_d[k]   = src;
            amt_d[k]    = amt_q[k-1];
            sticky_d[k] = sticky_q[k-1];
            if (amt_q[k-1][SHW-k]) begin
                case (mode_q[k-1])
                    MODE_LSL, MODE_NORM: data_d[k] = src << sh;
                    MODE_LSR:            data_d[k] = src >> sh;
                    default:             data_d[k] = $signed(src) >>> sh;
                endcase
                // Only bits that fall off the bottom count toward sticky.
                if (mode_q[k-1] == MODE_LSR || mode_q[k-1] == MODE_ASR) begin
                    sticky_d[k] = sticky_q[k-1] | (|(src & ~({WIDTH{1'b1}} << sh)));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned k = 0; k <= SHW; k++) begin
                data_q[k]   <= '0;
                amt_q[k]    <= '0;
                sticky_q[k] <= 1'b0;
            end
            for (int unsigned k = 0; k < SHW; k++) begin
                mode_q[k] <= MODE_LSL;
            end
        end else begin
            for (int unsigned k = 0; k <= SHW; k++) begin
                if (load[k]) begin
                    valid_q[k] <= feed_valid[k];
                    if (feed_valid[k]) begin
                        data_q[k]   <= data_d[k];
                        amt_q[k]    <= amt_d[k];
                        sticky_q[k] <= sticky_d[k];
                    end
                end
            end
            for (int unsigned k = 0; k < SHW; k++) begin
                if (load[k] && feed_valid[k]) begin
                    mode_q[k] <= mode_d[k];
                end
            end
        end
    end

    assign out_valid  = valid_q[SHW];
    assign out_data   = data_q[SHW];
    assign out_amt    = amt_q[SHW];
    assign out_sticky = sticky_q[SHW];
    assign out_zero   = ~|data_q[SHW];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=24): directed vectors, stall burst, reset flush.
module tb_pipe_shifter;

    localparam int W   = 24;
    localparam int SHW = 5;
    localparam int LAT = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic [SHW-1:0] in_amt = '0;
    logic [1:0]     in_mode = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [SHW-1:0] out_amt;
    logic           out_sticky;
    logic           out_zero;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [W-1:0]   d;
        logic [SHW-1:0] a;
        logic           s;
        logic           z;
        bit             lat;
        int unsigned    acc;
    } exp_t;

    exp_t sb[$];

    pipe_shifter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_amt(out_amt),
        .out_sticky(out_sticky), .out_zero(out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: in_ready occupancy model, stall stability, ordered scoreboard pops.
    int unsigned        occ = 0;
    bit                 held = 0;
    logic [W+SHW+1:0]   hval;
    exp_t               e;
    always @(negedge clk) begin
        if (rst) begin
            occ  = 0;
            held = 0;
        end else begin
            check("in_ready", in_ready, (occ < 6) || out_ready);
            if (out_valid && !out_ready) begin
                if (held) check("stall_hold", {out_data, out_amt, out_sticky, out_zero}, hval);
                else begin
                    held = 1;
                    hval = {out_data, out_amt, out_sticky, out_zero};
                end
            end else begin
                held = 0;
            end
            if (out_valid && out_ready) begin
                check("out_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_amt", out_amt, e.a);
                    check("out_sticky", out_sticky, e.s);
                    check("out_zero", out_zero, e.z);
                    if (e.lat) check("latency", cyc - e.acc, LAT);
                end
            end
            if (in_valid && in_ready) occ++;
            if (out_valid && out_ready) occ--;
        end
    end

    task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic [SHW-1:0] a,
                        input logic [W-1:0] ed, input logic [SHW-1:0] ea, input logic es,
                        input logic ez, input bit lat);
        exp_t x;
        int unsigned n;
        n        = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_amt   = a;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                x.d = ed; x.a = ea; x.s = es; x.z = ez; x.lat = lat; x.acc = cyc;
                sb.push_back(x);
                break;
            end
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=in_ready_low required=accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_amt", out_amt, 0);
        check("rst_out_sticky", out_sticky, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        logic [W-1:0] ed;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // mode: 0 LSL, 1 LSR, 2 ASR, 3 NORM
        send(0, 24'h000001, 23, 24'h800000, 23, 0, 0, 1); drain();
        send(1, 24'h00000F,  2, 24'h000003,  2, 1, 0, 1); drain();
        send(2, 24'h800000,  4, 24'hF80000,  4, 0, 0, 1); drain();
        send(2, 24'h7FFFFF, 31, 24'h000000, 31, 1, 1, 1); drain();
        send(3, 24'h000100,  7, 24'h800000, 15, 0, 0, 1); drain();
        send(3, 24'h000000,  0, 24'h000000, 24, 0, 1, 1); drain();
        send(0, 24'hABCDEF, 24, 24'h000000, 24, 0, 1, 1); drain();
        send(1, 24'h000001, 24, 24'h000000, 24, 1, 1, 1); drain();
        send(2, 24'h800001, 24, 24'hFFFFFF, 24, 1, 0, 1); drain();
        send(0, 24'hFFFFFF,  0, 24'hFFFFFF,  0, 0, 0, 1); drain();
        send(2, 24'hC00003,  1, 24'hE00001,  1, 1, 0, 1); drain();
        send(3, 24'h400000,  0, 24'h800000,  1, 0, 0, 1); drain();
        send(0, 24'h123456,  4, 24'h234560,  4, 0, 0, 1); drain();
        send(3, 24'h000001, 31, 24'h800000, 23, 0, 0, 1); drain();
        send(1, 24'hF0F0F0, 12, 24'h000F0F, 12, 1, 0, 1); drain();
        send(0, 24'hFFFFFF, 31, 24'h000000, 31, 0, 1, 1); drain();

        // Twenty back-to-back beats with the sink stalled for cycles 8..14.
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    out_ready = !(t >= 8 && t <= 14);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    if (i % 2 == 0) begin
                        ed = 24'h000001 << i;
                        send(0, 24'h000001, SHW'(i), ed, SHW'(i), 0, 0, 0);
                    end else begin
                        ed = 24'h800000 >> i;
                        send(1, 24'h800000, SHW'(i), ed, SHW'(i), 0, 0, 0);
                    end
                end
            end
        join
        drain();

        // Reset with three beats in flight: none may surface afterwards.
        send(0, 24'h000005, 1, 24'h00000A, 1, 0, 0, 0);
        send(1, 24'h000050, 4, 24'h000005, 4, 0, 0, 0);
        send(2, 24'h800000, 1, 24'hC00000, 1, 0, 0, 0);
        rst = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_rst2", in_ready, 1);
        send(0, 24'h000003, 1, 24'h000006, 1, 0, 0, 1);
        drain();
        repeat (20) @(posedge clk);
        #1;
        check("no_stale_beats", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
